uart_tx: RTL and testbench
==========================

# uart_tx

Byte-serial UART transmitter that turns an 8-bit parallel word into an asynchronous serial frame: start bit, 8 data bits LSB first, optional parity bit, then 1 or 2 stop bits. A programmable divider sets the bit rate. It sits between a host or CPU write port and the TX pin. `busy_o` both flow-controls the host and protects the frame in flight from being overwritten.

## Interface
Parameters: none. Data width is fixed at 8 bits and the divider at 16 bits.

- `clock_i` in 1: system clock; all logic is on the rising edge.
- `reset_i` in 1: one clock; reset is synchronous and active-low.
- `write_i` in 1: transmit request; level-sampled only while idle.
- `data_i` in 8: byte to send; captured when a request is accepted.
- `two_stop_bits_i` in 1: 1 selects two stop bits, 0 selects one.
- `parity_bit_i` in 1: 1 inserts a parity bit after data bit 7.
- `parity_even_i` in 1: 1 selects even parity, 0 selects odd.
- `clock_divider_i` in 16: bit time in clock cycles; 0 is treated as 1.
- `serial_o` out 1: serial line; idles high.
- `busy_o` out 1: high while in reset or while a frame is in progress.

## Operation
- **Reset** (`reset_i` low at a rising edge):
  - `serial_o`=1, `busy_o`=1; any frame in progress is aborted.
  - On the first edge with `reset_i` high: state IDLE, `busy_o`=0, `serial_o`=1.
- **FSM states:** IDLE, START, DATA (bit index 0..7), PARITY, STOP1, STOP2.
- **IDLE:**
  - `serial_o`=1, `busy_o`=0.
  - On an edge with `write_i`=1, the block latches `data_i`, `two_stop_bits_i`, `parity_bit_i`, `parity_even_i` and `clock_divider_i` (0→1).
  - On that same edge it enters START, drives `serial_o`=0 and `busy_o`=1.
- **START → DATA:** after one bit time. DATA sends latched bit 0 first and bit 7 last, one bit time each.
- **DATA → next:** goes to PARITY if parity is enabled, otherwise to STOP1.
- **PARITY:** one bit time.
  - Even parity: bit = XOR of the 8 latched bits.
  - Odd parity: bit = inverted XOR.
- **STOP1:** `serial_o`=1 for one bit time. Then goes to STOP2 if two stop bits are selected, otherwise to IDLE.
- **STOP2:** `serial_o`=1 for one bit time, then goes to IDLE.
- **While `busy_o`=1:**
  - `write_i` and all configuration inputs are ignored.
  - Changes to `data_i` have no effect on the frame in flight.
- **Holding `write_i` high:** if it is still high once IDLE is reached, a new frame starts on the next edge.
- **`busy_o` invariant:** every transition on `serial_o` occurs while `busy_o`=1 (after the update on that edge).

## Timing
- Bit time T = latched divider value, in clock cycles.
- **Accept edge E0:** start bit begins at E0.
  - Data bit n begins at E0 + (n+1)·T.
  - Parity (if enabled) begins at E0 + 9T.
  - Stop bits follow immediately after the last data/parity bit.
- **Frame length L** = 10T, +T for parity, +T for a second stop bit.
- **End of frame:** `busy_o` falls at edge E0 + L, when the state returns to IDLE.
  - That edge does not accept `write_i`.
  - The earliest next accept is E0 + L + 1 cycle, so there is a minimum of 1 idle cycle between frames.
- **Divider of 1:** one bit per clock cycle; an 8N1 frame is 10 cycles with `busy_o` high.
- **Counter:** a 16-bit counter down-counts from T−1 per bit; the bit advances when it reaches 0.
- **Divider changes** take effect only at the next accept.

## Test plan
1. **Reset:** hold `reset_i`=0 for 2 cycles → `busy_o`=1 and `serial_o`=1. Release → `busy_o`=0 on the next edge and `serial_o` stays 1.
2. **8N1 at divider 1:** write 0x55.
   - Expected sequence, one cycle each: 0 (start), 1,0,1,0,1,0,1,0, then 1 (stop).
   - `busy_o` is high for exactly 10 cycles.
   - No `serial_o` edge occurs while `busy_o`=0.
3. **Overwrite:** after accepting 0x55, set `data_i`=0xAA and `write_i`=1 during data bits 3–4, then drop `write_i` → the frame still carries 0x55 and `busy_o` is low after the stop bit.
4. **Parity and stop bits at divider 4:**
   - 0xA5, even parity → parity bit 0.
   - 0xA5, odd parity → parity bit 1.
   - Two stop bits: the line is high for 8 cycles after the parity bit, and `busy_o` spans 48 cycles.
5. **Divider edge values:**
   - Divider 0 behaves as 1.
   - Divider 3 gives 3-cycle bits.
   - Changing the divider mid-frame has no effect.
6. **Back-to-back and reset:**
   - `write_i` held high → consecutive frames separated by exactly 1 idle cycle.
   - Asserting reset mid-frame → `serial_o`=1 immediately at that edge and the frame is aborted.

Source files
------------

// File: rtl/uart_tx.sv
// Byte-serial UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// The bit rate comes from a 16-bit divider that is latched with each accepted byte.
module uart_tx (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        write_i,
  input  logic [7:0]  data_i,
  input  logic        two_stop_bits_i,
  input  logic        parity_bit_i,
  input  logic        parity_even_i,
  input  logic [15:0] clock_divider_i,
  output logic        serial_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  state_t      state_q, state_d;
  logic [2:0]  bit_q, bit_d, bit_nxt;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_q, div_d;
  logic [7:0]  data_q, data_d;
  logic        two_stop_q, two_stop_d;
  logic        par_en_q, par_en_d;
  logic        par_even_q, par_even_d;
  logic        serial_d, busy_d;

  function automatic logic parity_of(input logic [7:0] d, input logic even);
    return even ? (^d) : ~(^d);
  endfunction

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    data_d     = data_q;
    two_stop_d = two_stop_q;
    par_en_d   = par_en_q;
    par_even_d = par_even_q;
    serial_d   = serial_o;
    busy_d     = busy_o;
    bit_nxt    = bit_q + 3'd1;

    case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        busy_d   = 1'b0;
        if (write_i) begin
          data_d     = data_i;
          two_stop_d = two_stop_bits_i;
          par_en_d   = parity_bit_i;
          par_even_d = parity_even_i;
          div_d      = (clock_divider_i == 16'd0) ? 16'd1 : clock_divider_i;
          cnt_d      = div_d - 16'd1;
          state_d    = START;
          serial_d   = 1'b0;
          busy_d     = 1'b1;
        end
      end
      default: begin
        busy_d = 1'b1;
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          // Bit time expired: reload the counter and present the next symbol.
          cnt_d = div_q - 16'd1;
          case (state_q)
            START: begin
              state_d  = DATA;
              bit_d    = 3'd0;
              serial_d = data_q[0];
            end
            DATA: begin
              if (bit_q == 3'd7) begin
                if (par_en_q) begin
                  state_d  = PARITY;
                  serial_d = parity_of(data_q, par_even_q);
                end else begin
                  state_d  = STOP1;
                  serial_d = 1'b1;
                end
              end else begin
                bit_d    = bit_nxt;
                serial_d = data_q[bit_nxt];
              end
            end
            PARITY: begin
              state_d  = STOP1;
              serial_d = 1'b1;
            end
            STOP1: begin
              serial_d = 1'b1;
              if (two_stop_q) begin
                state_d = STOP2;
              end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
              end
            end
            STOP2: begin
              serial_d = 1'b1;
              state_d  = IDLE;
              busy_d   = 1'b0;
            end
            default: begin
              state_d  = IDLE;
              serial_d = 1'b1;
              busy_d   = 1'b0;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q  <= IDLE;
      bit_q    <= 3'd0;
      cnt_q    <= 16'd0;
      serial_o <= 1'b1;
      busy_o   <= 1'b1;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      serial_o <= serial_d;
      busy_o   <= busy_d;
    end
  end

  // Frame contents and configuration are only meaningful once a byte is accepted.
  always_ff @(posedge clock_i) begin
    div_q      <= div_d;
    data_q     <= data_d;
    two_stop_q <= two_stop_d;
    par_en_q   <= par_en_d;
    par_even_q <= par_even_d;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a frame-level reference model compared every cycle,
// plus directed frames with hand-computed waveform expectations.
module tb_uart_tx;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        write_i;
  logic [7:0]  data_i;
  logic        two_stop_bits_i;
  logic        parity_bit_i;
  logic        parity_even_i;
  logic [15:0] clock_divider_i;
  logic        serial_o;
  logic        busy_o;

  always #5 clock_i = ~clock_i;

  uart_tx dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .write_i        (write_i),
    .data_i         (data_i),
    .two_stop_bits_i(two_stop_bits_i),
    .parity_bit_i   (parity_bit_i),
    .parity_even_i  (parity_even_i),
    .clock_divider_i(clock_divider_i),
    .serial_o       (serial_o),
    .busy_o         (busy_o)
  );

  int   errors = 0;
  int   checks = 0;
  bit   chk_en = 1'b0;
  logic ser [0:63];
  logic bsy [0:63];

  // Reference model state: queue of line levels still owed for the frame in flight.
  bit   q_exp[$];
  logic exp_ser  = 1'b1;
  logic exp_busy = 1'b1;
  bit   m_idle   = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  initial begin : model
    int   t;
    logic pb;
    forever begin
      @(posedge clock_i);
      if (reset_i == 1'b0) begin
        q_exp.delete();
        exp_ser  = 1'b1;
        exp_busy = 1'b1;
        m_idle   = 1'b1;
      end else if (m_idle && write_i) begin
        t = (clock_divider_i == 16'd0) ? 1 : int'(clock_divider_i);
        for (int k = 0; k < t; k++) q_exp.push_back(1'b0);
        for (int b = 0; b < 8; b++)
          for (int k = 0; k < t; k++) q_exp.push_back(data_i[b]);
        if (parity_bit_i) begin
          pb = 1'b0;
          for (int b = 0; b < 8; b++) pb = pb ^ data_i[b];
          if (!parity_even_i) pb = ~pb;
          for (int k = 0; k < t; k++) q_exp.push_back(pb);
        end
        for (int k = 0; k < (two_stop_bits_i ? 2 * t : t); k++) q_exp.push_back(1'b1);
        exp_ser  = q_exp.pop_front();
        exp_busy = 1'b1;
        m_idle   = 1'b0;
      end else if (!m_idle) begin
        if (q_exp.size() > 0) begin
          exp_ser  = q_exp.pop_front();
          exp_busy = 1'b1;
        end else begin
          exp_ser  = 1'b1;
          exp_busy = 1'b0;
          m_idle   = 1'b1;
        end
      end else begin
        exp_ser  = 1'b1;
        exp_busy = 1'b0;
      end
    end
  end

  initial begin : compare
    logic prev_ser;
    prev_ser = 1'b1;
    forever begin
      @(negedge clock_i);
      if (chk_en) begin
        chk("serial_vs_model", serial_o, exp_ser);
        chk("busy_vs_model", busy_o, exp_busy);
        if (serial_o !== prev_ser) chk("edge_while_busy", busy_o, 1'b1);
        prev_ser = serial_o;
      end
    end
  end

  task automatic begin_frame(input logic [7:0] d, input logic [15:0] div,
                             input logic par, input logic even, input logic two);
    @(negedge clock_i);
    data_i          = d;
    clock_divider_i = div;
    parity_bit_i    = par;
    parity_even_i   = even;
    two_stop_bits_i = two;
    write_i         = 1'b1;
  endtask

  // Sample i is the line state after accept edge + i; optional mid-frame disturbance.
  task automatic record(input int n, input int ow_lo, input int ow_hi, input logic hold);
    for (int i = 0; i < n; i++) begin
      @(negedge clock_i);
      ser[i] = serial_o;
      bsy[i] = busy_o;
      if (i == 0) write_i = hold;
      if (i == ow_lo) begin
        data_i          = 8'hAA;
        clock_divider_i = 16'd7;
        parity_bit_i    = 1'b1;
        write_i         = 1'b1;
      end
      if (i == ow_hi) write_i = 1'b0;
    end
  endtask

  function automatic int count_busy(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (bsy[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_high(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (ser[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic logic [9:0] pack10();
    logic [9:0] p;
    for (int i = 0; i < 10; i++) p[i] = ser[i];
    return p;
  endfunction

  initial begin
    reset_i         = 1'b0;
    write_i         = 1'b0;
    data_i          = 8'h00;
    two_stop_bits_i = 1'b0;
    parity_bit_i    = 1'b0;
    parity_even_i   = 1'b1;
    clock_divider_i = 16'd1;

    // Reset held for two edges, then released.
    @(negedge clock_i);
    @(negedge clock_i);
    chk("reset_busy", busy_o, 1'b1);
    chk("reset_serial", serial_o, 1'b1);
    chk_en  = 1'b1;
    reset_i = 1'b1;
    @(negedge clock_i);
    chk("release_busy", busy_o, 1'b0);
    chk("release_serial", serial_o, 1'b1);

    // 8N1, divider 1, 0x55
    begin_frame(8'h55, 16'd1, 1'b0, 1'b1, 1'b0);
    record(12, -1, -1, 1'b0);
    chk("8n1_bits", pack10(), 10'h2AA);
    chk("8n1_busy_len", count_busy(0, 11), 10);
    chk("8n1_idle_after", bsy[10], 1'b0);

    // Overwrite attempt during data bits 3-4
    begin_frame(8'h55, 16'd1, 1'b0, 1'b1, 1'b0);
    record(12, 3, 5, 1'b0);
    chk("ovw_bits", pack10(), 10'h2AA);
    chk("ovw_busy_low", bsy[10], 1'b0);
    chk("ovw_still_idle", bsy[11], 1'b0);

    // Divider 4, 0xA5, even parity, one stop bit
    begin_frame(8'hA5, 16'd4, 1'b1, 1'b1, 1'b0);
    record(46, -1, -1, 1'b0);
    chk("even_parity", ser[37], 1'b0);
    chk("d4_bit0", ser[5], 1'b1);
    chk("d4_bit1", ser[9], 1'b0);
    chk("d4_busy_len", count_busy(0, 45), 44);

    // Divider 4, 0xA5, odd parity
    begin_frame(8'hA5, 16'd4, 1'b1, 1'b0, 1'b0);
    record(46, -1, -1, 1'b0);
    chk("odd_parity", ser[37], 1'b1);

    // Divider 4, parity plus two stop bits
    begin_frame(8'hA5, 16'd4, 1'b1, 1'b1, 1'b1);
    record(50, -1, -1, 1'b0);
    chk("two_stop_high", count_high(40, 47), 8);
    chk("two_stop_busy_len", count_busy(0, 49), 48);
    chk("two_stop_end", bsy[48], 1'b0);

    // Divider 0 behaves as 1
    begin_frame(8'h55, 16'd0, 1'b0, 1'b1, 1'b0);
    record(12, -1, -1, 1'b0);
    chk("div0_bits", pack10(), 10'h2AA);
    chk("div0_busy_len", count_busy(0, 11), 10);

    // Divider 3, with a divider change mid-frame
    begin_frame(8'h01, 16'd3, 1'b0, 1'b1, 1'b0);
    record(32, 5, 6, 1'b0);
    chk("d3_start", ser[2], 1'b0);
    chk("d3_bit0_first", ser[3], 1'b1);
    chk("d3_bit0_last", ser[5], 1'b1);
    chk("d3_bit1", ser[6], 1'b0);
    chk("d3_busy_len", count_busy(0, 31), 30);
    chk("d3_end", bsy[30], 1'b0);

    // Back-to-back frames with write held high
    begin_frame(8'h55, 16'd1, 1'b0, 1'b1, 1'b0);
    record(26, -1, 20, 1'b1);
    chk("b2b_gap", bsy[10], 1'b0);
    chk("b2b_restart_busy", bsy[11], 1'b1);
    chk("b2b_restart_start", ser[11], 1'b0);
    chk("b2b_busy_total", count_busy(0, 25), 20);

    // Reset asserted mid-frame
    begin_frame(8'h00, 16'd4, 1'b0, 1'b1, 1'b0);
    record(6, -1, -1, 1'b0);
    chk("abort_pre_bit0", ser[5], 1'b0);
    reset_i = 1'b0;
    @(negedge clock_i);
    chk("abort_serial", serial_o, 1'b1);
    chk("abort_busy", busy_o, 1'b1);
    reset_i = 1'b1;
    @(negedge clock_i);
    chk("abort_release_busy", busy_o, 1'b0);
    chk("abort_release_serial", serial_o, 1'b1);
    repeat (8) @(negedge clock_i);
    chk("abort_stays_idle", busy_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
